// File: rtl/simon_key_schedule_serial_pkg.sv
// Shared constants and types for the bit-serial SIMON-128/128 key schedule.
package simon_key_schedule_serial_pkg;

   localparam int unsigned WORD_W     = 64;
   localparam int unsigned KEY_W      = 128;
   localparam int unsigned NUM_ROUNDS = 68;
   localparam int unsigned BIT_W      = 6;
   localparam int unsigned ROUND_W    = 7;
   localparam int unsigned Z2_LEN     = 62;

   // z2 sequence written first element leftmost: z2[0] sits in bit 61
   localparam logic [Z2_LEN-1:0] Z2 =
      62'b1010_1111_0111_0000_0011_0100_1001_1000_1010_0001_0001_1111_1001_0110_1100_11;

   localparam logic [WORD_W-1:0]  C_CONST    = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   // data_rdy encodings (2'd1 is hold)
   localparam logic [1:0] MODE_CLEAR = 2'd0;
   localparam logic [1:0] MODE_LOAD  = 2'd2;
   localparam logic [1:0] MODE_RUN   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Element idx of the z2 sequence
   function automatic logic z2_bit(input logic [BIT_W-1:0] idx);
      return Z2[BIT_W'(Z2_LEN - 1) - idx];
   endfunction

endpackage

// File: rtl/simon_key_schedule_serial_z2_seq.sv
// 62-state sequencer producing z2[round mod 62]; advances once per round.
module simon_z2_seq
   import simon_key_schedule_serial_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic adv_i,
   output logic z_o
);

   logic [BIT_W-1:0] idx_q, idx_d;

   // Next index: clear wins, otherwise wrap 61 -> 0 on advance
   always_comb begin
      idx_d = idx_q;
      if (clr_i) begin
         idx_d = '0;
      end else if (adv_i) begin
         idx_d = (idx_q == BIT_W'(Z2_LEN - 1)) ? '0 : idx_q + BIT_W'(1);
      end
   end

   // Index register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) idx_q <= '0;
      else     idx_q <= idx_d;
   end

   assign z_o = z2_bit(idx_q);

endmodule

// File: rtl/simon_key_schedule_serial.sv
// Bit-serial SIMON-128/128 key schedule: loads the master key serially and
// emits one round-key bit per cycle, LSB first, for 68 rounds.
// Optional feature macro: SIMON_KEY_RELOAD_EN (shadow copy of the master key
// restored on DONE -> IDLE so consecutive runs need no reload).
module simon_key_schedule_serial
   import simon_key_schedule_serial_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   data_rdy,
   input  logic         key_in,
   output logic         key_out,
   output logic [6:0]   round_idx,
   output logic         round_parity,
   output logic         last_round,
   output logic         done
);

   // key_q = {k[i+1], k[i]} rotated right by the bit count; key_q[0] is the
   // bit on air, new bits of k[i+2] enter at the top.
   state_e               state_q;
   logic                 done_q;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [ROUND_W-1:0]   round_q, round_d;

   logic clr, load_step, run_step, bit_last, round_last, restore;
   logic z_bit, z_adv, k1_r3, k1_r4, new_bit;

   // Control decode shared by the FSM and the datapath
   always_comb begin
      clr        = (data_rdy == MODE_CLEAR);
      load_step  = (data_rdy == MODE_LOAD) && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
      run_step   = (data_rdy == MODE_RUN) && (state_q == ST_RUN);
      bit_last   = (bit_q == BIT_W'(WORD_W - 1));
      round_last = (round_q == LAST_ROUND);
      z_adv      = run_step && bit_last && !round_last;
      restore    = clr && (state_q == ST_DONE);
   end

   // ror(k[i+1],3) and ror(k[i+1],4) bits; near the word end they have
   // already rotated down into the low half
   always_comb begin
      k1_r3   = (bit_q >= BIT_W'(WORD_W - 3)) ? key_q[3] : key_q[WORD_W + 3];
      k1_r4   = (bit_q >= BIT_W'(WORD_W - 4)) ? key_q[4] : key_q[WORD_W + 4];
      new_bit = C_CONST[bit_q] ^ (z_bit & (bit_q == '0)) ^ key_q[0] ^ k1_r3 ^ k1_r4;
   end

   simon_z2_seq u_z2_seq (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .adv_i (z_adv),
      .z_o   (z_bit)
   );

`ifdef SIMON_KEY_RELOAD_EN
   logic [KEY_W-1:0] shadow_q;

   // Shadow follows the key register while it is being loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            shadow_q <= '0;
      else if (load_step) shadow_q <= {key_in, shadow_q[KEY_W-1:1]};
   end
`endif

   // Datapath next state: clear counters, serial load, or one schedule step
   always_comb begin
      key_d   = key_q;
      bit_d   = bit_q;
      round_d = round_q;
      if (clr) begin
         bit_d   = '0;
         round_d = '0;
`ifdef SIMON_KEY_RELOAD_EN
         if (restore) key_d = shadow_q;
`endif
      end else if (load_step) begin
         key_d = {key_in, key_q[KEY_W-1:1]};
      end else if (run_step) begin
         key_d = {new_bit, key_q[KEY_W-1:1]};
         bit_d = bit_q + BIT_W'(1);
         if (bit_last && !round_last) round_d = round_q + ROUND_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q   <= '0;
         bit_q   <= '0;
         round_q <= '0;
      end else begin
         key_q   <= key_d;
         bit_q   <= bit_d;
         round_q <= round_d;
      end
   end

   // Mode FSM with registered done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (data_rdy == MODE_LOAD)     state_q <= ST_LOAD;
               else if (data_rdy == MODE_RUN) state_q <= ST_RUN;
            end
            ST_LOAD: begin
               if (clr)                       state_q <= ST_IDLE;
               else if (data_rdy == MODE_RUN) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (clr) begin
                  state_q <= ST_IDLE;
               end else if (run_step && bit_last && round_last) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (clr) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign key_out      = (state_q == ST_RUN) & key_q[0];
   assign round_idx    = round_q;
   assign round_parity = round_q[0];
   assign last_round   = round_last;
   assign done         = done_q;

endmodule

// File: tb/tb_simon_key_schedule_serial.sv
// Directed bench for simon_key_schedule_serial with an independent
// word-level key-schedule model.
module tb_simon_key_schedule_serial;
   import simon_key_schedule_serial_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] data_rdy;
   logic       key_in;
   logic       key_out;
   logic [6:0] round_idx;
   logic       round_parity;
   logic       last_round;
   logic       done;

   simon_key_schedule_serial dut (
      .clk          (clk),
      .rst          (rst),
      .data_rdy     (data_rdy),
      .key_in       (key_in),
      .key_out      (key_out),
      .round_idx    (round_idx),
      .round_parity (round_parity),
      .last_round   (last_round),
      .done         (done)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] KEY   = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [63:0]  C_REF = 64'hFFFF_FFFF_FFFF_FFFC;
   string z2s = "10101111011100000011010010011000101000010001111110010110110011";

   typedef struct {
      int         cyc;
      logic [6:0] round;
      logic       parity;
      logic       last;
      logic       dn;
   } vec_t;
   localparam int NV = 10;
   vec_t tbl [NV];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] rk  [0:69];
   logic [63:0] got [0:69];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   task automatic build_model(input logic [127:0] k);
      rk[0] = k[63:0];
      rk[1] = k[127:64];
      for (int i = 0; i < 68; i++) begin
         logic [63:0] z;
         z = (z2s[i % 62] == "1") ? 64'd1 : 64'd0;
         rk[i+2] = C_REF ^ z ^ rk[i] ^ ror(rk[i+1], 3) ^ ror(rk[i+1], 4);
      end
   endtask

   // extra leading 1-bits precede the key to exercise overflow of the loader
   task automatic load_key(input logic [127:0] k, input int extra);
      data_rdy = 2'd2;
      for (int i = 0; i < extra + 128; i++) begin
         key_in = (i < extra) ? 1'b1 : k[i - extra];
         step();
      end
      key_in   = 1'b0;
      data_rdy = 2'd1;
   endtask

   task automatic run_rounds(input int first, input int n);
      for (int r = first; r < first + n; r++)
         for (int b = 0; b < 64; b++) begin
            got[r][b] = key_out;
            step();
         end
   endtask

   initial begin
      int          pulses;
      int          bad;
      logic [63:0] exp0, exp1;

      tbl[0] = '{0,    7'd0,  1'b0, 1'b0, 1'b0};
      tbl[1] = '{63,   7'd0,  1'b0, 1'b0, 1'b0};
      tbl[2] = '{64,   7'd1,  1'b1, 1'b0, 1'b0};
      tbl[3] = '{127,  7'd1,  1'b1, 1'b0, 1'b0};
      tbl[4] = '{128,  7'd2,  1'b0, 1'b0, 1'b0};
      tbl[5] = '{4287, 7'd66, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{4288, 7'd67, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{4351, 7'd67, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{4352, 7'd67, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{4353, 7'd67, 1'b1, 1'b1, 1'b0};

      rst = 1'b1; data_rdy = 2'd0; key_in = 1'b0;
      #12;
      check("reset_outputs", {key_out, round_idx, round_parity, last_round, done}, '0);
      check("reset_state", dut.state_q, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Full 68-round run
      build_model(KEY);
      load_key(KEY, 0);
      data_rdy = 2'd3;
      step();
      pulses = 0;
      for (int cyc = 0; cyc < 4354; cyc++) begin
         for (int t = 0; t < NV; t++)
            if (tbl[t].cyc == cyc)
               check($sformatf("status_cyc%0d", cyc), {round_idx, round_parity, last_round, done},
                     {tbl[t].round, tbl[t].parity, tbl[t].last, tbl[t].dn});
         if (cyc < 4352) got[cyc / 64][cyc % 64] = key_out;
         if (done) pulses++;
         step();
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (key_out !== 1'b0 || done !== 1'b0) bad++;
         if (done) pulses++;
         step();
      end
      check("done_hold_quiet", bad, 0);
      check("done_pulses", pulses, 1);
      check("round0_literal", got[0], 64'h0706050403020100);
      check("round1_literal", got[1], 64'h0f0e0d0c0b0a0908);
      for (int r = 0; r < 68; r++)
         check($sformatf("round_key_%0d", r), got[r], rk[r]);

      // Back-to-back run without reloading
      data_rdy = 2'd0;
      step();
      data_rdy = 2'd3;
      step();
      run_rounds(0, 2);
`ifdef SIMON_KEY_RELOAD_EN
      exp0 = KEY[63:0];
      exp1 = KEY[127:64];
`else
      exp0 = rk[68];
      exp1 = rk[69];
`endif
      check("b2b_round0", got[0], exp0);
      check("b2b_round1", got[1], exp1);
      check("b2b_round_idx", round_idx, 7'd2);
      data_rdy = 2'd0;
      step();
      check("clear_round_idx", round_idx, 7'd0);

      // Overlong load, then pause at round 5 bit 20
      load_key(KEY, 8);
      data_rdy = 2'd3;
      step();
      run_rounds(0, 5);
      for (int b = 0; b < 20; b++) begin
         got[5][b] = key_out;
         step();
      end
      data_rdy = 2'd1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (round_idx !== 7'd5 || key_out !== rk[5][20]) bad++;
      end
      check("hold_frozen", bad, 0);
      data_rdy = 2'd3;
      check("resume_bit", key_out, rk[5][20]);
      for (int b = 20; b < 64; b++) begin
         got[5][b] = key_out;
         step();
      end
      run_rounds(6, 1);
      check("overlong_round0", got[0], KEY[63:0]);
      check("overlong_round1", got[1], KEY[127:64]);
      check("pause_round5", got[5], rk[5]);
      check("pause_round6", got[6], rk[6]);

      // Reset mid-run at round 30
      run_rounds(7, 23);
      for (int b = 0; b < 10; b++) step();
      check("pre_reset_round", round_idx, 7'd30);
      rst = 1'b1;
      #1;
      check("midrun_reset_outputs", {key_out, round_idx, round_parity, last_round, done}, '0);
      check("midrun_reset_state", dut.state_q, ST_IDLE);
      check("midrun_reset_key", dut.key_q, '0);
      @(negedge clk);
      rst = 1'b0;
      data_rdy = 2'd3;
      step();
      run_rounds(0, 1);
      check("post_reset_round0", got[0], 64'd0);
      data_rdy = 2'd0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/simon_key_schedule_serial.md
SIMON_KEY_SCHEDULE_SERIAL -- requirements
Module: simon_key_schedule_serial

Interface
REQ-001 Parameters: none; all sizes are fixed constants in the shared package (word 64 bits, key 128 bits, 68 rounds).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock shared with the datapath.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 data_rdy  input  2  mode: 0 clear, 1 plaintext load (hold), 2 key load, 3 run.
REQ-006 key_in  input  1  serial master-key bit, LSB of k0 first, sampled when data_rdy==2.
REQ-007 key_out  output  1  current round-key bit, feeds the datapath key_in.
REQ-008 round_idx  output  7  current round number 0..67.
REQ-009 round_parity  output  1  round_idx[0], drives the datapath round_counter.
REQ-010 last_round  output  1  high while round_idx==67.
REQ-011 done  output  1  single-cycle pulse after the final key bit.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN, DONE.
- IDLE->LOAD on data_rdy==2; IDLE->RUN on data_rdy==3; any state->IDLE on data_rdy==0.
- LOAD->RUN on data_rdy==3; RUN->DONE after the 64th bit of round 67; DONE holds until data_rdy==0.
REQ-013 In LOAD, each cycle SHALL shift key_in into a 128-bit register: first 64 bits form k0, next 64 form k1. After 128 bits, further bits displace the oldest.
REQ-014 data_rdy==1 SHALL hold all key state, counters and FSM state.
REQ-015 In RUN, key_out SHALL be combinationally equal to bit b of round key k[i] while the internal 6-bit bit counter equals b and round_idx equals i. Bits are emitted LSB first, one bit per cycle, with zero added latency.
REQ-016 Round keys SHALL satisfy k[i+2] = c ^ z2[i mod 62] ^ k[i] ^ ror(k[i+1],3) ^ ror(k[i+1],4), where c = 64'hFFFF_FFFF_FFFF_FFFC. z2 enters at bit 0 only.
REQ-017 The bit counter SHALL wrap 63->0 and increment round_idx in the same cycle. round_idx SHALL never exceed 67.
REQ-018 done SHALL pulse for exactly one cycle on the RUN->DONE edge.
REQ-019 In DONE, key_out SHALL be 0 and data_rdy==3 SHALL be ignored.
REQ-020 data_rdy==0 SHALL clear the bit counter and round_idx and SHALL preserve the key registers.
REQ-021 A change of data_rdy mid-round SHALL take effect at the next edge with no partial-bit correction. Bench protocol forbids this.

Reset
REQ-022 On rst, every register SHALL clear: FSM=IDLE, key registers=0, counters=0, key_out=0, round_idx=0, round_parity=0, last_round=0, done=0.
REQ-023 Reset asserted mid-RUN SHALL abort immediately. A key reload SHALL be required after reset.

Configuration
REQ-024 With SIMON_KEY_RELOAD_EN defined:
- A 128-bit shadow SHALL capture the master key during LOAD.
- On the DONE->IDLE transition, the schedule registers SHALL be restored from the shadow, so back-to-back encryptions need no reload.
REQ-025 Without SIMON_KEY_RELOAD_EN:
- No shadow register SHALL exist.
- The schedule registers SHALL keep their end-of-run contents, and software SHALL reload the key before the next run.

Structure
REQ-026 The shared package SHALL hold WORD_W=64, KEY_W=128, NUM_ROUNDS=68, the Z2 62-bit constant, the C constant, and the FSM state typedef.
REQ-027 One sub-module SHALL be used: simon_z2_seq, a 62-state sequencer producing z2[i mod 62] and advancing on round increment.

Verification
REQ-028 Load key 128'h0f0e0d0c0b0a0908_0706050403020100, then run. Round 0 key_out SHALL serialise 64'h0706050403020100 LSB first; round 1 SHALL serialise 64'h0f0e0d0c0b0a0908.
REQ-029 Run the same key for a full 68x64 cycles. All round keys SHALL match the package-driven reference model; done SHALL pulse exactly once at cycle 4352 and round_idx SHALL read 67.
REQ-030 Toggle data_rdy 3->1->3 at round 5, bit 20. Output SHALL resume at bit 20 of round 5 with no skipped bits.
REQ-031 Assert rst at round 30. All outputs SHALL be 0 within the same cycle, and FSM=IDLE.
REQ-032 Run two encryptions back to back without reloading:
- With SIMON_KEY_RELOAD_EN, round 0 of the second run SHALL again emit 64'h0706050403020100.
- Without it, the second run's round-0 key SHALL equal the stored end-of-run state.
REQ-033 Hold data_rdy==3 after done. key_out SHALL stay 0 and done SHALL not re-pulse until data_rdy==0 then 3.
